// File: rtl/decoder_stream.sv
// decoder_stream: pipelined select-code decoder on a valid/ready stream.
// A binary select code plus a mode is decoded into one-hot, thermometer or
// their inverses. The result is registered, and a skid register behind the
// output register lets the block run at full throughput under backpressure
// without any combinational path from out_ready to in_ready.
module decoder_stream #(
   parameter int SEL_W = 3,
   parameter int OUT_W = 8,
   parameter int CNT_W = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [SEL_W-1:0] in_sel,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_err,
   output logic [CNT_W-1:0] err_count,
   input  logic             clr_count
);

   // Buffer occupancy, encoded as {out_valid, skid_full}
   localparam logic [1:0] ST_EMPTY = 2'b00;
   localparam logic [1:0] ST_ONE   = 2'b10;
   localparam logic [1:0] ST_TWO   = 2'b11;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic             out_valid_q;
   logic [OUT_W-1:0] out_data_q;
   logic             out_err_q;
   logic             skid_full;
   logic [OUT_W-1:0] skid_data;
   logic             skid_err;
   logic [CNT_W-1:0] err_cnt_q;

   logic             accept;
   logic             consume;
   logic [1:0]       buf_state;

   int               sel_int;
   logic [OUT_W-1:0] onehot_vec;
   logic [OUT_W-1:0] therm_vec;
   logic [OUT_W-1:0] dec_data;
   logic             dec_err;

   assign in_ready  = !skid_full;
   assign accept    = in_valid && in_ready;
   assign consume   = out_valid_q && out_ready;
   assign buf_state = {out_valid_q, skid_full};

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_err   = out_err_q;
   assign err_count = err_cnt_q;

   // Decode the presented code; out-of-range codes naturally give an all-zero
   // one-hot and a saturated thermometer, and the inverted modes follow
   always_comb begin
      sel_int    = int'(in_sel);
      onehot_vec = '0;
      therm_vec  = '0;
      dec_data   = '0;
      dec_err    = (sel_int >= OUT_W);
      for (int i = 0; i < OUT_W; i++) begin
         onehot_vec[i] = (i == sel_int);
         therm_vec[i]  = (i <= sel_int);
      end
      case (in_mode)
         2'b00:   dec_data = onehot_vec;
         2'b01:   dec_data = therm_vec;
         2'b10:   dec_data = ~onehot_vec;
         default: dec_data = ~therm_vec;
      endcase
   end

   // Two-entry buffer: output register in front, skid register behind it
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_err_q   <= 1'b0;
         skid_full   <= 1'b0;
         skid_data   <= '0;
         skid_err    <= 1'b0;
      end else begin
         case (buf_state)
            ST_EMPTY: begin
               if (accept) begin
                  out_valid_q <= 1'b1;
                  out_data_q  <= dec_data;
                  out_err_q   <= dec_err;
               end
            end
            ST_ONE: begin
               if (accept && consume) begin
                  out_data_q <= dec_data;
                  out_err_q  <= dec_err;
               end else if (accept) begin
                  skid_full <= 1'b1;
                  skid_data <= dec_data;
                  skid_err  <= dec_err;
               end else if (consume) begin
                  out_valid_q <= 1'b0;
               end
            end
            ST_TWO: begin
               if (consume) begin
                  out_data_q <= skid_data;
                  out_err_q  <= skid_err;
                  skid_full  <= 1'b0;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               skid_full   <= 1'b0;
            end
         endcase
      end
   end

   // Saturating count of accepted out-of-range codes; clear beats increment
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         err_cnt_q <= '0;
      end else if (clr_count) begin
         err_cnt_q <= '0;
      end else if (accept && dec_err && (err_cnt_q != CNT_MAX)) begin
         err_cnt_q <= err_cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_decoder_stream.sv
// tb_decoder_stream: directed vectors plus a queue scoreboard for decoder_stream
// with SEL_W=3, OUT_W=6 and a 2-bit error counter so saturation is reachable.
module tb_decoder_stream;

   logic       clock;
   logic       reset_n;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] in_sel;
   logic [1:0] in_mode;
   logic       out_valid;
   logic       out_ready;
   logic [5:0] out_data;
   logic       out_err;
   logic [1:0] err_count;
   logic       clr_count;

   int n_compared = 0;
   int n_failed   = 0;

   typedef struct packed {
      logic [5:0] data;
      logic       err;
   } word_t;

   typedef struct {
      logic [2:0] sel;
      logic [1:0] mode;
      logic [5:0] exp_data;
      logic       exp_err;
      logic [1:0] exp_cnt;
   } vec_t;

   vec_t  vecs[12];
   word_t sb_q[$];
   int    model_cnt;
   int    words_out;

   decoder_stream #(.SEL_W(3), .OUT_W(6), .CNT_W(2)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sel    (in_sel),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_err   (out_err),
      .err_count (err_count),
      .clr_count (clr_count)
   );

   // Free-running 10 ns clock
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Hard stop in case something never terminates
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [2:0] sel, input logic [1:0] mode,
                                input logic ordy, input logic clr);
      in_valid  = v;
      in_sel    = sel;
      in_mode   = mode;
      out_ready = ordy;
      clr_count = clr;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic doReset();
      reset_n = 1'b0;
      applyStimulus(1'b0, 3'd0, 2'd0, 1'b0, 1'b0);
      step();
      reset_n = 1'b1;
   endtask

   // Reference decode built from shifts rather than per-bit loops
   function automatic word_t refDecode(input logic [2:0] sel, input logic [1:0] mode);
      logic [8:0] oh;
      logic [8:0] th;
      word_t w;
      oh = 9'd1 << sel;
      th = (9'd2 << sel) - 9'd1;
      case (mode)
         2'd0:    w.data = oh[5:0];
         2'd1:    w.data = th[5:0];
         2'd2:    w.data = ~oh[5:0];
         default: w.data = ~th[5:0];
      endcase
      w.err = (sel >= 3'd6);
      return w;
   endfunction

   task automatic runScoreboard(input int n_words, input bit random_flow);
      int    sent;
      int    guard;
      bit    model_ready;
      logic  v;
      word_t exp_word;
      sent      = 0;
      guard     = 0;
      words_out = 0;
      while ((sent < n_words || sb_q.size() != 0) && guard < 5000) begin
         guard++;
         v = (sent < n_words) && (random_flow ? ($urandom_range(0, 3) != 0) : 1'b1);
         applyStimulus(v, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                       random_flow ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
         checkOutput("sb_out_valid", 32'(out_valid), 32'(sb_q.size() != 0));
         checkOutput("sb_in_ready", 32'(in_ready), 32'(sb_q.size() < 2));
         model_ready = (sb_q.size() < 2);
         if (out_ready && sb_q.size() != 0) begin
            exp_word = sb_q.pop_front();
            checkOutput("sb_out_data", 32'(out_data), 32'(exp_word.data));
            checkOutput("sb_out_err", 32'(out_err), 32'(exp_word.err));
            words_out++;
         end
         if (in_valid && model_ready) begin
            exp_word = refDecode(in_sel, in_mode);
            sb_q.push_back(exp_word);
            sent++;
            if (exp_word.err && model_cnt < 3) model_cnt++;
         end
         step();
         checkOutput("sb_err_count", 32'(err_count), 32'(model_cnt));
      end
      checkOutput("sb_drained", 32'(sb_q.size()), 32'd0);
      checkOutput("sb_words_out", 32'(words_out), 32'(n_words));
      if (!random_flow) checkOutput("sb_cycles", 32'(guard), 32'(n_words + 1));
   endtask

   // Main test sequence
   initial begin
      vecs[0]  = '{3'd2, 2'd0, 6'b000100, 1'b0, 2'd0};
      vecs[1]  = '{3'd2, 2'd1, 6'b000111, 1'b0, 2'd0};
      vecs[2]  = '{3'd2, 2'd2, 6'b111011, 1'b0, 2'd0};
      vecs[3]  = '{3'd2, 2'd3, 6'b111000, 1'b0, 2'd0};
      vecs[4]  = '{3'd7, 2'd0, 6'b000000, 1'b1, 2'd1};
      vecs[5]  = '{3'd7, 2'd1, 6'b111111, 1'b1, 2'd2};
      vecs[6]  = '{3'd6, 2'd2, 6'b111111, 1'b1, 2'd3};
      vecs[7]  = '{3'd0, 2'd3, 6'b111110, 1'b0, 2'd3};
      vecs[8]  = '{3'd5, 2'd1, 6'b111111, 1'b0, 2'd3};
      vecs[9]  = '{3'd5, 2'd0, 6'b100000, 1'b0, 2'd3};
      vecs[10] = '{3'd6, 2'd3, 6'b000000, 1'b1, 2'd3};
      vecs[11] = '{3'd0, 2'd2, 6'b111110, 1'b0, 2'd3};

      reset_n = 1'b0;
      applyStimulus(1'b0, 3'd0, 2'd0, 1'b0, 1'b0);
      step();
      step();
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_out_data", 32'(out_data), 32'd0);
      checkOutput("rst_out_err", 32'(out_err), 32'd0);
      checkOutput("rst_err_count", 32'(err_count), 32'd0);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
      reset_n = 1'b1;

      $display("[TB] mode sweep and out-of-range vectors");
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1'b1, vecs[i].sel, vecs[i].mode, 1'b1, 1'b0);
         step();
         checkOutput($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'd1);
         checkOutput($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vecs[i].exp_data));
         checkOutput($sformatf("vec%0d_out_err", i), 32'(out_err), 32'(vecs[i].exp_err));
         checkOutput($sformatf("vec%0d_err_count", i), 32'(err_count), 32'(vecs[i].exp_cnt));
         checkOutput($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
      end

      $display("[TB] counter saturation and clear");
      doReset();
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 3'd7, 2'd0, 1'b1, 1'b0);
         step();
         checkOutput($sformatf("sat%0d_err_count", i), 32'(err_count), (i < 3) ? 32'(i + 1) : 32'd3);
      end
      applyStimulus(1'b1, 3'd7, 2'd0, 1'b1, 1'b1);
      step();
      checkOutput("clr_with_accept", 32'(err_count), 32'd0);
      applyStimulus(1'b1, 3'd7, 2'd0, 1'b1, 1'b0);
      step();
      checkOutput("after_clr_count", 32'(err_count), 32'd1);
      applyStimulus(1'b0, 3'd6, 2'd1, 1'b1, 1'b0);
      step();
      checkOutput("idle_err_count", 32'(err_count), 32'd1);
      checkOutput("idle_out_valid", 32'(out_valid), 32'd0);

      $display("[TB] backpressure");
      doReset();
      applyStimulus(1'b1, 3'd0, 2'd0, 1'b0, 1'b0);
      step();
      checkOutput("bp1_out_data", 32'(out_data), 32'b000001);
      checkOutput("bp1_in_ready", 32'(in_ready), 32'd1);
      applyStimulus(1'b1, 3'd1, 2'd0, 1'b0, 1'b0);
      step();
      checkOutput("bp2_out_data", 32'(out_data), 32'b000001);
      checkOutput("bp2_in_ready", 32'(in_ready), 32'd0);
      applyStimulus(1'b1, 3'd2, 2'd0, 1'b0, 1'b0);
      step();
      checkOutput("bp3_out_data", 32'(out_data), 32'b000001);
      checkOutput("bp3_in_ready", 32'(in_ready), 32'd0);
      step();
      checkOutput("bp4_out_data", 32'(out_data), 32'b000001);
      checkOutput("bp4_out_valid", 32'(out_valid), 32'd1);
      applyStimulus(1'b1, 3'd2, 2'd0, 1'b1, 1'b0);
      step();
      checkOutput("bp5_out_data", 32'(out_data), 32'b000010);
      checkOutput("bp5_in_ready", 32'(in_ready), 32'd1);
      step();
      checkOutput("bp6_out_data", 32'(out_data), 32'b000100);
      checkOutput("bp6_out_valid", 32'(out_valid), 32'd1);
      applyStimulus(1'b0, 3'd0, 2'd0, 1'b1, 1'b0);
      step();
      checkOutput("bp7_out_valid", 32'(out_valid), 32'd0);

      $display("[TB] reset mid-stream");
      applyStimulus(1'b1, 3'd7, 2'd1, 1'b0, 1'b0);
      step();
      step();
      checkOutput("mid_full_in_ready", 32'(in_ready), 32'd0);
      reset_n = 1'b0;
      step();
      checkOutput("mid_out_valid", 32'(out_valid), 32'd0);
      checkOutput("mid_in_ready", 32'(in_ready), 32'd1);
      checkOutput("mid_err_count", 32'(err_count), 32'd0);
      checkOutput("mid_out_data", 32'(out_data), 32'd0);
      step();
      checkOutput("mid_rst_prio_valid", 32'(out_valid), 32'd0);
      checkOutput("mid_rst_prio_count", 32'(err_count), 32'd0);
      reset_n = 1'b1;
      applyStimulus(1'b1, 3'd3, 2'd0, 1'b1, 1'b0);
      step();
      checkOutput("mid_next_valid", 32'(out_valid), 32'd1);
      checkOutput("mid_next_data", 32'(out_data), 32'b001000);
      checkOutput("mid_next_err", 32'(out_err), 32'd0);

      $display("[TB] full-throughput scoreboard");
      doReset();
      sb_q.delete();
      model_cnt = 0;
      runScoreboard(100, 1'b0);

      $display("[TB] random-flow scoreboard");
      doReset();
      sb_q.delete();
      model_cnt = 0;
      runScoreboard(100, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
      $finish;
   end

endmodule
